// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// A one-byte holding register lets the next byte queue so frames run back-to-back.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          stop_idx, stop_idx_next;
    logic [7:0]    shift, shift_next;
    logic          parity_bit, parity_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic [7:0]    hold_data, hold_data_next;
    logic          hold_full, hold_full_next;
    logic          bit_end, load, accept;

    assign ready = ~hold_full;
    assign tx    = tx_reg;
    assign busy  = busy_reg;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
        end else begin
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_idx    <= bit_idx_next;
            stop_idx   <= stop_idx_next;
            shift      <= shift_next;
            parity_bit <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            hold_data  <= hold_data_next;
            hold_full  <= hold_full_next;
        end
    end

    // tx is computed one clock ahead so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_next     = state;
        clk_cnt_next   = clk_cnt;
        bit_idx_next   = bit_idx;
        stop_idx_next  = stop_idx;
        shift_next     = shift;
        parity_next    = parity_bit;
        tx_next        = tx_reg;
        hold_data_next = hold_data;
        hold_full_next = hold_full;

        bit_end = (clk_cnt == LAST_CLK);
        load    = hold_full &&
                  ((state == IDLE) || (state == STOP && bit_end && stop_idx == LAST_STOP));
        accept  = send && !hold_full;

        if (state != IDLE)
            clk_cnt_next = bit_end ? '0 : clk_cnt + 1'b1;

        case (state)
            IDLE: ;
            START: if (bit_end) begin
                state_next   = DATA;
                bit_idx_next = 3'd0;
                tx_next      = shift[0];
            end
            DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
                    if (PARITY != 0) begin
                        state_next = PAR;
                        tx_next    = parity_bit;
                    end else begin
                        state_next    = STOP;
                        stop_idx_next = 1'b0;
                        tx_next       = 1'b1;
                    end
                end else begin
                    shift_next   = {1'b0, shift[7:1]};
                    tx_next      = shift[1];
                    bit_idx_next = bit_idx + 3'd1;
                end
            end
            PAR: if (bit_end) begin
                state_next    = STOP;
                stop_idx_next = 1'b0;
                tx_next       = 1'b1;
            end
            STOP: if (bit_end) begin
                if (stop_idx == LAST_STOP) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end else begin
                    stop_idx_next = stop_idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A load overrides the stop-to-idle step so the next start bit follows with no gap.
        if (load) begin
            state_next     = START;
            clk_cnt_next   = '0;
            shift_next     = hold_data;
            parity_next    = (PARITY == 2) ? ~^hold_data : ^hold_data;
            tx_next        = 1'b0;
            hold_full_next = 1'b0;
        end
        if (accept) begin
            hold_data_next = data;
            hold_full_next = 1'b1;
        end

        busy_next = (state_next != IDLE) || hold_full_next;
    end

endmodule
